// File: rtl/fcp_tx_framer_if.sv
// Request/status bundle between the FCP slave logical layer and the TX framer.
interface fcp_tx_framer_if;
  logic        pl_tx_en;
  logic        pl_tx_type;
  logic [15:0] pl_tx_data;
  logic        tx_abort;
  logic        tx_dout;
  logic        tx_oe;
  logic        tx_done;
  logic        tx_busy;
  logic        tx_drop;

  modport master (
    output pl_tx_en, pl_tx_type, pl_tx_data, tx_abort,
    input  tx_dout, tx_oe, tx_done, tx_busy, tx_drop
  );

  modport slave (
    input  pl_tx_en, pl_tx_type, pl_tx_data, tx_abort,
    output tx_dout, tx_oe, tx_done, tx_busy, tx_drop
  );
endinterface

// File: rtl/fcp_tx_framer.sv
// FCP single-wire transmit framer: serialises a slave PING or a RESPOND frame
// (data bytes + CRC-8 + trailing ping) at UI resolution, with abort support.
module fcp_tx_framer #(
  parameter int unsigned UI_CYCLES = 16,
  parameter int unsigned PING_UI   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  fcp_tx_framer_if.slave   bus
);

  localparam int unsigned UW = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;
  localparam int unsigned PW = (PING_UI > 1) ? $clog2(PING_UI) : 1;
  localparam int unsigned BW = (PW > 4) ? PW : 4;

  localparam logic [UW-1:0] UI_LAST   = UW'(UI_CYCLES - 1);
  localparam logic [BW-1:0] PING_LAST = BW'(PING_UI - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(10);

  typedef enum logic [1:0] {ST_IDLE, ST_BYTE, ST_PING} state_e;
  typedef enum logic [1:0] {SEL_HI, SEL_LO, SEL_CRC} sel_e;

  state_e        state_q, state_d;
  sel_e          byte_sel_q, byte_sel_d;
  logic [UW-1:0] ui_cnt_q, ui_cnt_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [15:0]   data_q, data_d;
  logic [7:0]    crc_q, crc_d;
  logic          dout_q, dout_d;
  logic          oe_q, oe_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          drop_q, drop_d;

  logic          ui_end;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] sel_byte(input sel_e sel, input logic [15:0] d,
                                          input logic [7:0] crc);
    case (sel)
      SEL_HI:  return d[15:8];
      SEL_LO:  return d[7:0];
      default: return crc;
    endcase
  endfunction

  assign ui_end   = (ui_cnt_q == UI_LAST);
  assign cur_byte = sel_byte(byte_sel_q, data_q, crc_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      byte_sel_q <= SEL_HI;
      ui_cnt_q   <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      crc_q      <= '0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      ui_cnt_q   <= ui_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    ui_cnt_d   = ui_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    crc_d      = crc_q;
    if (bus.tx_abort) begin
      state_d   = ST_IDLE;
      ui_cnt_d  = '0;
      bit_idx_d = '0;
      crc_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pl_tx_en) begin
            data_d    = bus.pl_tx_data;
            crc_d     = '0;
            ui_cnt_d  = '0;
            bit_idx_d = '0;
            if (bus.pl_tx_type) begin
              state_d    = ST_BYTE;
              byte_sel_d = (bus.pl_tx_data[15:8] != 8'h00) ? SEL_HI : SEL_LO;
            end else begin
              state_d = ST_PING;
            end
          end
        end
        ST_BYTE: begin
          if (!ui_end) begin
            ui_cnt_d = ui_cnt_q + 1'b1;
          end else begin
            ui_cnt_d = '0;
            if (bit_idx_q != BIT_LAST) begin
              bit_idx_d = bit_idx_q + 1'b1;
            end else begin
              bit_idx_d = '0;
              // CRC folds in each data byte as it finishes, ready before the CRC byte starts
              case (byte_sel_q)
                SEL_HI: begin
                  crc_d      = crc8_byte(crc_q, cur_byte);
                  byte_sel_d = SEL_LO;
                end
                SEL_LO: begin
                  crc_d      = crc8_byte(crc_q, cur_byte);
                  byte_sel_d = SEL_CRC;
                end
                default: state_d = ST_PING;
              endcase
            end
          end
        end
        ST_PING: begin
          if (!ui_end) begin
            ui_cnt_d = ui_cnt_q + 1'b1;
          end else begin
            ui_cnt_d = '0;
            if (bit_idx_q != PING_LAST) begin
              bit_idx_d = bit_idx_q + 1'b1;
            end else begin
              bit_idx_d = '0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Line outputs are registered from the next-state view so they align with the UI counters.
  always_comb begin
    logic [7:0]    nb;
    logic [BW-1:0] pos;
    nb     = sel_byte(byte_sel_d, data_d, crc_d);
    pos    = BW'(8) - bit_idx_d;
    dout_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
    oe_d   = busy_d;
    done_d = !bus.tx_abort && (state_q == ST_PING) && ui_end && (bit_idx_q == PING_LAST);
    drop_d = !bus.tx_abort && bus.pl_tx_en && (state_q != ST_IDLE);
    case (state_d)
      ST_PING: dout_d = 1'b1;
      ST_BYTE: begin
        if (bit_idx_d == '0)              dout_d = 1'b1;
        else if (bit_idx_d <= BW'(8))     dout_d = nb[pos[2:0]];
        else if (bit_idx_d == BW'(9))     dout_d = ~^nb;
        else                              dout_d = 1'b0;
      end
      default: dout_d = 1'b0;
    endcase
  end

  assign bus.tx_dout = dout_q;
  assign bus.tx_oe   = oe_q;
  assign bus.tx_done = done_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_drop = drop_q;

endmodule

// File: tb/tb_fcp_tx_framer.sv
// Directed self-checking bench for fcp_tx_framer with UI_CYCLES=16, PING_UI=16.
module tb_fcp_tx_framer;

  localparam int UI = 16;
  localparam int PU = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fcp_tx_framer_if bus();

  fcp_tx_framer #(.UI_CYCLES(UI), .PING_UI(PU)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic cap_oe   [0:1023];
  logic cap_dout [0:1023];
  logic cap_done [0:1023];
  logic cap_busy [0:1023];
  logic cap_drop [0:1023];
  int   cap_cyc  [0:1023];

  task automatic send(input logic typ, input logic [15:0] d);
    @(negedge clk);
    bus.pl_tx_en   = 1'b1;
    bus.pl_tx_type = typ;
    bus.pl_tx_data = d;
    @(negedge clk);
    bus.pl_tx_en   = 1'b0;
    bus.pl_tx_type = 1'b0;
    bus.pl_tx_data = 16'hA5A5;
  endtask

  // Records n cycles of outputs; optionally injects a request or an abort at a given index.
  task automatic capture(input int n, input int req_at, input int abort_at);
    for (int i = 0; i < n; i++) begin
      cap_oe[i]   = bus.tx_oe;
      cap_dout[i] = bus.tx_dout;
      cap_done[i] = bus.tx_done;
      cap_busy[i] = bus.tx_busy;
      cap_drop[i] = bus.tx_drop;
      cap_cyc[i]  = cyc;
      if (i == req_at) begin
        bus.pl_tx_en = 1'b1; bus.pl_tx_type = 1'b1; bus.pl_tx_data = 16'hFFFF;
      end else if (i == req_at + 1) begin
        bus.pl_tx_en = 1'b0; bus.pl_tx_type = 1'b0; bus.pl_tx_data = 16'hA5A5;
      end
      if (i == abort_at) bus.tx_abort = 1'b1;
      else if (i == abort_at + 1) bus.tx_abort = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (bus.tx_oe   !== 1'b0) $display("FAIL reset_oe: got %b, want 0", bus.tx_oe);   else n_pass++;
    n_total++; if (bus.tx_dout !== 1'b0) $display("FAIL reset_dout: got %b, want 0", bus.tx_dout); else n_pass++;
    n_total++; if (bus.tx_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", bus.tx_done); else n_pass++;
    n_total++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", bus.tx_busy); else n_pass++;
    n_total++; if (bus.tx_drop !== 1'b0) $display("FAIL reset_drop: got %b, want 0", bus.tx_drop); else n_pass++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ping();
    int L;
    int first_oe;
    int last_oe;
    int done_cyc;
    L = PU * UI;
    while (cyc < 10) @(negedge clk);
    bus.pl_tx_en = 1'b1; bus.pl_tx_type = 1'b0; bus.pl_tx_data = 16'h1234;
    @(negedge clk);
    bus.pl_tx_en = 1'b0;
    capture(L + 4, -1, -1);
    first_oe = -1; last_oe = -1; done_cyc = -1;
    for (int i = 0; i < L + 4; i++) begin
      if (cap_oe[i] === 1'b1 && cap_dout[i] === 1'b1) begin
        if (first_oe < 0) first_oe = cap_cyc[i];
        last_oe = cap_cyc[i];
      end
      if (cap_done[i] === 1'b1 && done_cyc < 0) done_cyc = cap_cyc[i];
    end
    n_total++; if (first_oe !== 11)  $display("FAIL ping_first_high: got cycle %0d, want 11", first_oe);  else n_pass++;
    n_total++; if (last_oe !== 266)  $display("FAIL ping_last_high: got cycle %0d, want 266", last_oe);   else n_pass++;
    n_total++; if (done_cyc !== 267) $display("FAIL ping_done_cycle: got cycle %0d, want 267", done_cyc); else n_pass++;
    n_total++;
    if (cap_oe[L] !== 1'b0 || cap_dout[L] !== 1'b0 || cap_busy[L] !== 1'b0 || cap_done[L+1] !== 1'b0)
      $display("FAIL ping_end_state: oe=%b dout=%b busy=%b done_next=%b, want 0 0 0 0",
               cap_oe[L], cap_dout[L], cap_busy[L], cap_done[L+1]);
    else n_pass++;
  endtask

  task automatic test_respond_short();
    logic [63:0] exp;
    int N;
    int bad;
    N   = 38;
    exp = 64'({11'b1_00001000_0_0, 11'b1_00111000_0_0, 16'hFFFF});
    send(1'b1, 16'h0008);
    capture(N * UI + 2, -1, -1);
    for (int u = 0; u < N; u++) begin
      bad = -1;
      for (int k = 0; k < UI; k++)
        if (bad < 0 && (cap_oe[u*UI+k] !== 1'b1 || cap_busy[u*UI+k] !== 1'b1 ||
                        cap_done[u*UI+k] !== 1'b0 || cap_dout[u*UI+k] !== exp[N-1-u])) bad = k;
      n_total++;
      if (bad < 0) n_pass++;
      else $display("FAIL resp0008_ui%0d: cycle %0d oe=%b dout=%b done=%b, want oe=1 dout=%b done=0",
                    u, bad, cap_oe[u*UI+bad], cap_dout[u*UI+bad], cap_done[u*UI+bad], exp[N-1-u]);
    end
    n_total++;
    if (cap_done[N*UI] !== 1'b1 || cap_oe[N*UI] !== 1'b0 || cap_dout[N*UI] !== 1'b0 || cap_busy[N*UI] !== 1'b0)
      $display("FAIL resp0008_done: done=%b oe=%b dout=%b busy=%b, want 1 0 0 0",
               cap_done[N*UI], cap_oe[N*UI], cap_dout[N*UI], cap_busy[N*UI]);
    else n_pass++;
  endtask

  task automatic test_respond_long();
    logic [63:0] exp;
    int N;
    int bad;
    N   = 49;
    exp = 64'({11'b1_00001000_0_0, 11'b1_00000001_0_0, 11'b1_10101111_1_0, 16'hFFFF});
    send(1'b1, 16'h0801);
    capture(N * UI + 2, -1, -1);
    for (int u = 0; u < N; u++) begin
      bad = -1;
      for (int k = 0; k < UI; k++)
        if (bad < 0 && (cap_oe[u*UI+k] !== 1'b1 || cap_dout[u*UI+k] !== exp[N-1-u] ||
                        cap_done[u*UI+k] !== 1'b0)) bad = k;
      n_total++;
      if (bad < 0) n_pass++;
      else $display("FAIL resp0801_ui%0d: cycle %0d oe=%b dout=%b, want oe=1 dout=%b",
                    u, bad, cap_oe[u*UI+bad], cap_dout[u*UI+bad], exp[N-1-u]);
    end
    n_total++;
    if (cap_done[N*UI] !== 1'b1 || cap_oe[N*UI] !== 1'b0 || cap_done[N*UI+1] !== 1'b0)
      $display("FAIL resp0801_done: done=%b oe=%b done_next=%b, want 1 0 0",
               cap_done[N*UI], cap_oe[N*UI], cap_done[N*UI+1]);
    else n_pass++;
  endtask

  task automatic test_drop();
    logic [63:0] exp;
    int N;
    int bad;
    int drops;
    N   = 38;
    exp = 64'({11'b1_00001000_0_0, 11'b1_00111000_0_0, 16'hFFFF});
    send(1'b1, 16'h0008);
    capture(N * UI + 2, 100, -1);
    bad = -1;
    for (int i = 0; i < N * UI; i++)
      if (bad < 0 && (cap_oe[i] !== 1'b1 || cap_dout[i] !== exp[N-1-i/UI])) bad = i;
    n_total++;
    if (bad < 0) n_pass++;
    else $display("FAIL drop_serial: cycle %0d oe=%b dout=%b, want oe=1 dout=%b",
                  bad, cap_oe[bad], cap_dout[bad], exp[N-1-bad/UI]);
    drops = 0;
    for (int i = 0; i < N * UI + 2; i++) if (cap_drop[i] === 1'b1) drops++;
    n_total++; if (cap_drop[101] !== 1'b1) $display("FAIL drop_pulse: got %b, want 1", cap_drop[101]); else n_pass++;
    n_total++; if (drops !== 1) $display("FAIL drop_count: got %0d, want 1", drops); else n_pass++;
    n_total++; if (cap_done[N*UI] !== 1'b1) $display("FAIL drop_done: got %b, want 1", cap_done[N*UI]); else n_pass++;
  endtask

  task automatic test_abort();
    int n;
    int stray;
    int c;
    n = 38 * UI + 2;
    send(1'b1, 16'h0008);
    capture(n, -1, 15 * UI + 3);
    n_total++;
    if (cap_oe[243] !== 1'b1) $display("FAIL abort_pre_oe: got %b, want 1", cap_oe[243]); else n_pass++;
    n_total++;
    if (cap_oe[244] !== 1'b0 || cap_dout[244] !== 1'b0 || cap_busy[244] !== 1'b0)
      $display("FAIL abort_next: oe=%b dout=%b busy=%b, want 0 0 0", cap_oe[244], cap_dout[244], cap_busy[244]);
    else n_pass++;
    stray = 0;
    for (int i = 0; i < n; i++) begin
      if (cap_done[i] === 1'b1) stray++;
      if (i >= 244 && (cap_oe[i] !== 1'b0 || cap_busy[i] !== 1'b0)) stray++;
    end
    n_total++; if (stray !== 0) $display("FAIL abort_quiet: got %0d stray cycles, want 0", stray); else n_pass++;

    bus.pl_tx_en = 1'b1; bus.pl_tx_type = 1'b0; bus.tx_abort = 1'b1;
    @(negedge clk);
    bus.pl_tx_en = 1'b0; bus.tx_abort = 1'b0;
    n_total++;
    if (bus.tx_busy !== 1'b0 || bus.tx_oe !== 1'b0 || bus.tx_drop !== 1'b0)
      $display("FAIL abort_vs_req: busy=%b oe=%b drop=%b, want 0 0 0", bus.tx_busy, bus.tx_oe, bus.tx_drop);
    else n_pass++;

    send(1'b0, 16'h0000);
    c = 0;
    while (bus.tx_done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_total++; if (c !== PU * UI) $display("FAIL abort_then_ping: done after %0d cycles, want %0d", c, PU * UI); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    bus.pl_tx_en = 1'b1; bus.pl_tx_type = 1'b0;
    @(negedge clk);
    bus.pl_tx_en = 1'b0;
    n_total++;
    if (bus.tx_busy !== 1'b1 || bus.tx_oe !== 1'b1)
      $display("FAIL b2b_accept: busy=%b oe=%b, want 1 1", bus.tx_busy, bus.tx_oe);
    else n_pass++;
    c = 0;
    while (bus.tx_done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_total++; if (c !== PU * UI) $display("FAIL b2b_len: done after %0d cycles, want %0d", c, PU * UI); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int stray;
    send(1'b0, 16'h0000);
    repeat (5 * UI + 3) @(negedge clk);
    n_total++; if (bus.tx_oe !== 1'b1) $display("FAIL rst_mid_oe: got %b, want 1", bus.tx_oe); else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if (bus.tx_oe !== 1'b0 || bus.tx_dout !== 1'b0 || bus.tx_busy !== 1'b0)
      $display("FAIL rst_async: oe=%b dout=%b busy=%b, want 0 0 0", bus.tx_oe, bus.tx_dout, bus.tx_busy);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.tx_oe !== 1'b0 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_dout !== 1'b0) stray++;
      @(negedge clk);
    end
    n_total++; if (stray !== 0) $display("FAIL rst_idle: got %0d active cycles, want 0", stray); else n_pass++;
  endtask

  initial begin
    bus.pl_tx_en   = 1'b0;
    bus.pl_tx_type = 1'b0;
    bus.pl_tx_data = 16'h0000;
    bus.tx_abort   = 1'b0;
    test_reset();
    test_ping();
    test_respond_short();
    test_respond_long();
    test_drop();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
